// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads a word through a load/ready handshake and shifts
// out a programmable number of bits, MSB- or LSB-first, one bit per tick_i strobe.
module piso_serializer #(
    parameter int   Width     = 16,
    parameter int   CntW      = 5,
    parameter logic IdleLevel = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] din_i,
    input  logic [CntW-1:0]  len_i,
    input  logic             lsb_first_i,
    input  logic             load_i,
    output logic             ready_o,
    input  logic             tick_i,
    input  logic             abort_i,
    output logic             dout_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [Width-1:0] shreg;
    logic [CntW-1:0]  cnt;
    logic             lsb_q;
    logic             done_q;

    logic [CntW-1:0]  len_eff;
    logic [Width-1:0] load_word;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        len_eff   = len_i;
        load_word = din_i;
        if (len_i == '0 || 32'(len_i) > Width) begin
            len_eff = CntW'(Width);
        end
        // MSB-first frames left-justify the word so bit L-1 sits at the top of the register.
        if (!lsb_first_i) begin
            load_word = din_i << (CntW'(Width) - len_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
        if (rst_i) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            lsb_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_i) begin
                        shreg <= load_word;
                        cnt   <= len_eff;
                        lsb_q <= lsb_first_i;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort_i) begin
                        state <= IDLE;
                        shreg <= '0;
                        cnt   <= '0;
                    end else if (tick_i && cnt != '0) begin
                        shreg <= lsb_q ? (shreg >> 1) : (shreg << 1);
                        cnt   <= cnt - 1'b1;
                        if (cnt == CntW'(1)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = (state == IDLE) && !rst_i;
    assign busy_o  = (state == SHIFT);
    assign done_o  = done_q;
    assign dout_o  = busy_o ? (lsb_q ? shreg[0] : shreg[Width-1]) : IdleLevel;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (Width=8): stimulus pushes expected serial bits and done
// pulses into a scoreboard queue; a negedge monitor pops and compares them as the DUT emits.
module tb_piso_serializer;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic [C-1:0] len;
    logic         lsb_first;
    logic         load;
    logic         ready;
    logic         tick;
    logic         abort;
    logic         dout;
    logic         busy;
    logic         done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic is_done;
        logic bit_val;
    } exp_t;

    exp_t sb_q[$];

    piso_serializer #(.Width(W), .CntW(C), .IdleLevel(1'b0)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .din_i      (din),
        .len_i      (len),
        .lsb_first_i(lsb_first),
        .load_i     (load),
        .ready_o    (ready),
        .tick_i     (tick),
        .abort_i    (abort),
        .dout_o     (dout),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bits go out in the order exp[n-1] .. exp[0].
    task automatic expect_bits(input logic [15:0] exp, input int n);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.is_done = 1'b0;
            e.bit_val = exp[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic expect_done();
        exp_t e;
        e.is_done = 1'b1;
        e.bit_val = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic load_frame(input logic [W-1:0] d, input logic [C-1:0] l, input logic lsb);
        int n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        check("ready_before_load", ready, 1);
        din       = d;
        len       = l;
        lsb_first = lsb;
        load      = 1'b1;
        step();
        load = 1'b0;
        check("busy_after_load", busy, 1);
    endtask

    task automatic tick_bits(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            tick = 1'b0;
            for (int j = 1; j < period; j++) step();
            check("busy_in_frame", {busy, ready}, 2'b10);
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && busy && tick && !abort) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_bit: got unexpected bit %0b, expected none at %0t", dout, $time);
            end else begin
                e = sb_q.pop_front();
                check("serial_bit", {e.is_done, dout}, {1'b0, e.bit_val});
            end
        end
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_done: got unexpected done pulse, expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("done_pulse", {e.is_done, done}, 2'b11);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; din = '0; len = '0; lsb_first = 1'b0;
        load = 1'b0; tick = 1'b0; abort = 1'b0;
        step();
        step();
        check("reset_outputs", {ready, busy, done, dout}, 4'b0000);
        rst = 1'b0;
        step();
        check("ready_after_reset", ready, 1);

        // MSB-first, len 0 -> full width
        expect_bits(16'hA5, 8);
        expect_done();
        load_frame(8'hA5, 4'd0, 1'b0);
        tick_bits(8, 1);
        check("t1_end", {done, busy, ready}, 3'b101);
        step();
        check("t1_done_one_cycle", {done, dout}, 2'b00);

        // LSB-first, len 4, din 0x0B -> 1,1,0,1
        expect_bits(16'b1101, 4);
        expect_done();
        load_frame(8'h0B, 4'd4, 1'b1);
        tick_bits(4, 1);
        check("t2_done", done, 1);
        step();

        // LSB-first, len 12 clamps to 8, din 0x1E -> 0,1,1,1,1,0,0,0
        expect_bits(16'b01111000, 8);
        expect_done();
        load_frame(8'h1E, 4'd12, 1'b1);
        tick_bits(8, 1);
        check("t2_clamp_done", done, 1);
        step();

        // MSB-first, len 3, din 0xF5 -> 1,0,1
        expect_bits(16'b101, 3);
        expect_done();
        load_frame(8'hF5, 4'd3, 1'b0);
        tick_bits(3, 1);
        check("t3_done", done, 1);
        step();
        check("t3_idle_level", {dout, busy}, 2'b00);

        // tick every 4 cycles, mid-frame load ignored
        expect_bits(16'h81, 8);
        expect_done();
        load_frame(8'h81, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                load = (i == 2);
                din  = 8'h7E;
                step();
                check("t4_hold_bit", dout, (8'h81 >> (7 - i)) & 1);
                if (i == 2) check("t4_ready_low", ready, 0);
            end
            load = 1'b0;
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        check("t4_done", done, 1);
        step();

        // abort together with a tick after the 3rd bit
        expect_bits(16'b110, 3);
        load_frame(8'hC6, 4'd8, 1'b0);
        tick_bits(3, 1);
        abort = 1'b1;
        tick  = 1'b1;
        step();
        abort = 1'b0;
        tick  = 1'b0;
        check("t5_abort_idle", {busy, done, ready, dout}, 4'b0010);
        step();
        check("t5_no_done", done, 0);
        expect_bits(16'h3C, 8);
        expect_done();
        load_frame(8'h3C, 4'd0, 1'b0);
        tick_bits(8, 2);
        check("t5_new_frame_done", done, 1);
        step();

        // reset mid-frame
        expect_bits(16'b11, 2);
        load_frame(8'hFF, 4'd8, 1'b0);
        tick_bits(2, 1);
        rst  = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("t6_reset_mid", {ready, busy, done, dout}, 4'b0000);
        rst = 1'b0;
        step();
        check("t6_after_reset", {ready, busy, done}, 3'b100);

        // back-to-back: load accepted in the done cycle
        expect_bits(16'h96, 8);
        expect_done();
        load_frame(8'h96, 4'd0, 1'b0);
        tick_bits(8, 1);
        check("t6_done_ready", {done, ready}, 2'b11);
        expect_bits(16'b1010, 4);
        expect_done();
        load_frame(8'h05, 4'd4, 1'b1);
        check("t6_b2b_started", {busy, done}, 2'b10);
        tick_bits(4, 1);
        check("t6_b2b_done", done, 1);
        step();

        repeat (3) step();
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
